spram_arb: RTL and testbench
============================

SPRAM_ARB -- requirements
Module: spram_arb

Interface
REQ-001 Parameters (name, default, meaning):
- DATA_DEPTH, 16, RAM word count.
- DATA_WIDTH, 64, RAM word width.
- RD_DELAY, 1, RAM read latency (>=1), matching the attached spram.
- ADDR_WIDTH, (DATA_DEPTH>1)?$clog2(DATA_DEPTH):1, address width.
- RTSEL_VAL, 2'b00, constant driven on ram_rtsel.
- WTSEL_VAL, 2'b00, constant driven on ram_wtsel.

REQ-002 Ports (name, direction, width, meaning):
- clka  in  1  sole clock, rising edge.
- rsta  in  1  reset, synchronous, active-high.
- p0_req / p1_req  in  1  access request.
- p0_we / p1_we  in  1  1=write, 0=read.
- p0_addr / p1_addr  in  ADDR_WIDTH  word address.
- p0_wdata / p1_wdata  in  DATA_WIDTH  write data.
- p0_bwe / p1_bwe  in  DATA_WIDTH  per-bit write enable.
- p0_gnt / p1_gnt  out  1  request accepted this cycle.
- p0_rvalid / p1_rvalid  out  1  read data valid.
- p0_rdata / p1_rdata  out  DATA_WIDTH  read data.
- ram_ena  out  1  to spram ena.
- ram_wena  out  1  to spram wena.
- ram_addra  out  ADDR_WIDTH  to spram addra.
- ram_dina  out  DATA_WIDTH  to spram dina.
- ram_bwea  out  DATA_WIDTH  to spram bwea.
- ram_douta  in  DATA_WIDTH  from spram douta.
- ram_rtsel / ram_wtsel  out  2  RAM timing select.

Function
REQ-003 Handshake: a transfer occurs on port k in a cycle where pk_req=1 and pk_gnt=1. A requester shall hold req, we, addr, wdata and bwe stable until granted.
REQ-004 Grant logic is combinational from req and the priority pointer (ptr):
- At most one gnt is high per cycle.
- gnt is never high without the matching req.
REQ-005 Arbitration is round-robin:
- If only one port requests, that port is granted.
- If both request, port ptr is granted.
REQ-006 On any transfer to port k, ptr shall update to 1-k at the next edge. With no transfer, ptr holds.
REQ-007 Fairness: a port holding req continuously shall be granted within 2 cycles.
REQ-008 RAM command outputs are registered. A transfer in cycle N drives the following in cycle N+1, with values taken from the granted port:
- ram_ena=1
- ram_wena=pk_we
- ram_addra, ram_dina, ram_bwea
REQ-009 In a cycle N with no transfer, cycle N+1 has ram_ena=0 and ram_wena=0. ram_addra, ram_dina and ram_bwea hold their previous values.
REQ-010 A read transfer in cycle N shall assert pk_rvalid for exactly one cycle, N+1+RD_DELAY, with pk_rdata=ram_douta in that cycle.
REQ-011 Read tracking: a registered shift pipeline of depth RD_DELAY+1 carries a valid bit and a port id. Reads on both ports return in issue order, one rvalid per read.
REQ-012 pk_rdata shall be driven from ram_douta at all times. It is only meaningful while pk_rvalid=1.
REQ-013 Writes produce no rvalid.
REQ-014 Back-to-back transfers shall be accepted every cycle with no bubbles (throughput 1 access/cycle).
REQ-015 Ordering: a read granted after a write to the same address returns the written data for bits with bwe=1, and the old data for bits with bwe=0.
REQ-016 ram_rtsel=RTSEL_VAL and ram_wtsel=WTSEL_VAL at all times, including during reset.

Reset
REQ-017 While rsta=1 at a clka edge, the following are cleared:
- ptr=0
- ram_ena=0, ram_wena=0
- ram_addra=0, ram_dina=0, ram_bwea=0
- read pipeline valid bits=0, so p0_rvalid=0 and p1_rvalid=0
REQ-018 While rsta=1, p0_gnt=0 and p1_gnt=0.
REQ-019 Reads in flight when rsta asserts are discarded. No rvalid is produced for them after reset releases.
REQ-020 The first cycle after rsta deasserts is a normal arbitration cycle with ptr=0.

Verification
REQ-021 Single read, RD_DELAY=1: preload addr 3=0xA5. p0 read addr 3 granted at cycle N -> ram_ena=1, ram_wena=0, ram_addra=3 at N+1; p0_rvalid=1 with p0_rdata=0xA5 at N+2 only; p1_rvalid stays 0.
REQ-022 Contention after reset: p0_req=p1_req=1 held for 4 cycles -> gnt order p0, p1, p0, p1; never both gnt high.
REQ-023 Write then read, RD_DELAY=2:
- p1 writes addr 5, data 0xFFFF, bwe=0x00FF, over old value 0x1234.
- p0 then reads addr 5 in the next cycle.
- Required: p0_rdata=0x12FF, with p0_rvalid at grant cycle+3.
REQ-024 Streaming reads: p0 and p1 alternate reads on 8 consecutive cycles -> 8 rvalid pulses on 8 consecutive cycles, each on the issuing port with the correct data, in issue order.
REQ-025 Reset mid-flight: p0 read granted at N, rsta=1 at N+1 for 1 cycle -> no p0_rvalid afterwards; ram_ena=0 the cycle after reset; next p0/p1 contention grants p0 first.

Source files
------------

// File: rtl/spram_arb.sv
`default_nettype none
// spram_arb: two-port round-robin arbiter feeding a single-port RAM, with read-return tracking (rev 1.0)
module spram_arb #(
  parameter int          DATA_DEPTH = 16,
  parameter int          DATA_WIDTH = 64,
  parameter int          RD_DELAY   = 1,
  parameter int          ADDR_WIDTH = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1,
  parameter logic [1:0]  RTSEL_VAL  = 2'b00,
  parameter logic [1:0]  WTSEL_VAL  = 2'b00
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  input  logic [DATA_WIDTH-1:0] p0_bwe,
  output logic                  p0_gnt,
  output logic                  p0_rvalid,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  input  logic [DATA_WIDTH-1:0] p1_bwe,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  ram_ena,
  output logic                  ram_wena,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dina,
  output logic [DATA_WIDTH-1:0] ram_bwea,
  input  logic [DATA_WIDTH-1:0] ram_douta,
  output logic [1:0]            ram_rtsel,
  output logic [1:0]            ram_wtsel
);

  localparam int PIPE_DEPTH = RD_DELAY + 1;

  logic                  ptr;
  logic                  xfer;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [DATA_WIDTH-1:0] sel_bwe;
  logic [PIPE_DEPTH-1:0] pipe_vld;
  logic [PIPE_DEPTH-1:0] pipe_id;

  // ptr names the port that wins when both request
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (!rsta) begin
      if (p0_req && (!p1_req || !ptr)) p0_gnt = 1'b1;
      else if (p1_req)                 p1_gnt = 1'b1;
    end
  end

  always_comb begin
    xfer      = p0_gnt | p1_gnt;
    sel_we    = p1_gnt ? p1_we    : p0_we;
    sel_addr  = p1_gnt ? p1_addr  : p0_addr;
    sel_wdata = p1_gnt ? p1_wdata : p0_wdata;
    sel_bwe   = p1_gnt ? p1_bwe   : p0_bwe;
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      ptr       <= 1'b0;
      ram_ena   <= 1'b0;
      ram_wena  <= 1'b0;
      ram_addra <= '0;
      ram_dina  <= '0;
      ram_bwea  <= '0;
    end else begin
      if (xfer) ptr <= p0_gnt;
      ram_ena  <= xfer;
      ram_wena <= xfer & sel_we;
      if (xfer) begin
        ram_addra <= sel_addr;
        ram_dina  <= sel_wdata;
        ram_bwea  <= sel_bwe;
      end
    end
  end

  // Stage i is valid in the cycle i+1 after the read was granted
  always_ff @(posedge clka) begin
    if (rsta) begin
      pipe_vld <= '0;
      pipe_id  <= '0;
    end else begin
      pipe_vld[0] <= xfer & ~sel_we;
      pipe_id[0]  <= p1_gnt;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_id[i]  <= pipe_id[i-1];
      end
    end
  end

  assign p0_rvalid = pipe_vld[RD_DELAY] & ~pipe_id[RD_DELAY];
  assign p1_rvalid = pipe_vld[RD_DELAY] &  pipe_id[RD_DELAY];
  assign p0_rdata  = ram_douta;
  assign p1_rdata  = ram_douta;
  assign ram_rtsel = RTSEL_VAL;
  assign ram_wtsel = WTSEL_VAL;

endmodule
`default_nettype wire

// File: tb/tb_spram_arb.sv
`default_nettype none
// tb_spram_arb: scoreboard bench for spram_arb, two instances (read latency 1 and 2) on shared stimulus (rev 1.0)
`timescale 1ns/1ps
module tb_spram_arb;

  typedef struct {
    logic        port;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rsta;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  logic        req [2];
  logic        we [2];
  logic [3:0]  addr [2];
  logic [63:0] wdata [2];
  logic [63:0] bwe [2];

  logic [1:0]  gnt_d [2];
  logic [1:0]  rvalid_d [2];
  logic [63:0] rdata_d [2][2];
  logic        ram_ena_d [2];
  logic        ram_wena_d [2];
  logic [3:0]  ram_addr_d [2];
  logic [63:0] ram_din_d [2];
  logic [63:0] ram_bwe_d [2];
  logic [63:0] ram_dout_d [2];
  logic [1:0]  rtsel_d [2];
  logic [1:0]  wtsel_d [2];

  logic [63:0] ram_mem [2][16];
  logic [63:0] rd_mid;
  logic [63:0] ref_mem [16];
  logic        ref_init = 1'b0;

  exp_t        sbq [2][$];
  int          rv_cnt [2][2];
  logic [63:0] last_rd [2][2];

  logic        ptr_m = 1'b0;
  logic        exp_ena = 1'b0;
  logic        exp_wena = 1'b0;
  logic [3:0]  exp_addr = '0;
  logic [63:0] exp_din = '0;
  logic [63:0] exp_bwe = '0;
  logic [1:0]  eg;
  logic        kk;
  exp_t        ent;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spram_arb #(.DATA_DEPTH(16), .DATA_WIDTH(64), .RD_DELAY(1), .RTSEL_VAL(2'b01), .WTSEL_VAL(2'b10)) u_d1 (
    .clka(clk), .rsta(rsta),
    .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]), .p0_bwe(bwe[0]),
    .p0_gnt(gnt_d[0][0]), .p0_rvalid(rvalid_d[0][0]), .p0_rdata(rdata_d[0][0]),
    .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]), .p1_bwe(bwe[1]),
    .p1_gnt(gnt_d[0][1]), .p1_rvalid(rvalid_d[0][1]), .p1_rdata(rdata_d[0][1]),
    .ram_ena(ram_ena_d[0]), .ram_wena(ram_wena_d[0]), .ram_addra(ram_addr_d[0]),
    .ram_dina(ram_din_d[0]), .ram_bwea(ram_bwe_d[0]), .ram_douta(ram_dout_d[0]),
    .ram_rtsel(rtsel_d[0]), .ram_wtsel(wtsel_d[0])
  );

  spram_arb #(.DATA_DEPTH(16), .DATA_WIDTH(64), .RD_DELAY(2)) u_d2 (
    .clka(clk), .rsta(rsta),
    .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]), .p0_bwe(bwe[0]),
    .p0_gnt(gnt_d[1][0]), .p0_rvalid(rvalid_d[1][0]), .p0_rdata(rdata_d[1][0]),
    .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]), .p1_bwe(bwe[1]),
    .p1_gnt(gnt_d[1][1]), .p1_rvalid(rvalid_d[1][1]), .p1_rdata(rdata_d[1][1]),
    .ram_ena(ram_ena_d[1]), .ram_wena(ram_wena_d[1]), .ram_addra(ram_addr_d[1]),
    .ram_dina(ram_din_d[1]), .ram_bwea(ram_bwe_d[1]), .ram_douta(ram_dout_d[1]),
    .ram_rtsel(rtsel_d[1]), .ram_wtsel(wtsel_d[1])
  );

  function automatic logic [63:0] init_val(input int a);
    if (a == 3) return 64'hA5;
    if (a == 5) return 64'h1234;
    return 64'h1000_0000_0000_0000 | (64'(a) * 64'h111);
  endfunction

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endfunction

  // Attached single-port RAMs: latency 1 for u_d1, latency 2 for u_d2
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int a = 0; a < 16; a++) begin
        ram_mem[0][a] <= init_val(a);
        ram_mem[1][a] <= init_val(a);
      end
    end else begin
      for (int i = 0; i < 2; i++)
        if (ram_ena_d[i] && ram_wena_d[i])
          ram_mem[i][ram_addr_d[i]] <= (ram_mem[i][ram_addr_d[i]] & ~ram_bwe_d[i]) | (ram_din_d[i] & ram_bwe_d[i]);
      if (ram_ena_d[0] && !ram_wena_d[0]) ram_dout_d[0] <= ram_mem[0][ram_addr_d[0]];
      if (ram_ena_d[1] && !ram_wena_d[1]) rd_mid <= ram_mem[1][ram_addr_d[1]];
    end
    ram_dout_d[1] <= rd_mid;
  end

  // Checker: arbitration model, RAM command model, scoreboard producer
  always @(negedge clk) begin
    if (!ref_init) begin
      for (int a = 0; a < 16; a++) ref_mem[a] = init_val(a);
      ref_init = 1'b1;
    end
    if (cyc >= 1) begin
      for (int i = 0; i < 2; i++) begin
        chk("ram_ena", ram_ena_d[i], exp_ena);
        chk("ram_wena", ram_wena_d[i], exp_wena);
        chk("ram_addra", ram_addr_d[i], exp_addr);
        chk("ram_dina", ram_din_d[i], exp_din);
        chk("ram_bwea", ram_bwe_d[i], exp_bwe);
      end
    end
    chk("ram_rtsel_d1", rtsel_d[0], 2'b01);
    chk("ram_wtsel_d1", wtsel_d[0], 2'b10);
    chk("ram_rtsel_d2", rtsel_d[1], 2'b00);
    chk("ram_wtsel_d2", wtsel_d[1], 2'b00);

    eg = 2'b00;
    if (!rsta) begin
      if (req[0] && req[1]) eg = ptr_m ? 2'b10 : 2'b01;
      else                  eg = {req[1], req[0]};
    end
    chk("gnt_d1", gnt_d[0], eg);
    chk("gnt_d2", gnt_d[1], eg);

    if (rsta) begin
      ptr_m = 1'b0; exp_ena = 1'b0; exp_wena = 1'b0;
      exp_addr = '0; exp_din = '0; exp_bwe = '0;
      sbq[0].delete();
      sbq[1].delete();
    end else begin
      exp_ena  = |eg;
      exp_wena = 1'b0;
      if (|eg) begin
        kk       = eg[1];
        ptr_m    = ~kk;
        exp_wena = we[kk];
        exp_addr = addr[kk];
        exp_din  = wdata[kk];
        exp_bwe  = bwe[kk];
        if (we[kk]) begin
          ref_mem[addr[kk]] = (ref_mem[addr[kk]] & ~bwe[kk]) | (wdata[kk] & bwe[kk]);
        end else begin
          ent.port = kk; ent.data = ref_mem[addr[kk]];
          ent.cyc = cyc + 2; sbq[0].push_back(ent);
          ent.cyc = cyc + 3; sbq[1].push_back(ent);
        end
      end
    end
  end

  // Monitor: consumes read returns as the DUTs present them
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (rvalid_d[i][k]) begin
          rv_cnt[i][k]++;
          last_rd[i][k] = rdata_d[i][k];
          if (sbq[i].size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL rvalid_unexpected: dut %0d port %0d rvalid=1, required 0 (cycle %0d)", i, k, cyc);
          end else begin
            e = sbq[i].pop_front();
            chk("rvalid_port", 64'(k), 64'(e.port));
            chk("rdata", rdata_d[i][k], e.data);
            chk("rvalid_cycle", 64'(cyc), 64'(e.cyc));
          end
        end
      end
      while (sbq[i].size() > 0 && sbq[i][0].cyc < cyc) begin
        n_chk++; n_fail++;
        $display("FAIL rvalid_missing: dut %0d no rvalid, required one at cycle %0d", i, sbq[i][0].cyc);
        void'(sbq[i].pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req[0] = 1'b0;
    req[1] = 1'b0;
  endtask

  task automatic put(input int k, input logic w, input logic [3:0] a, input logic [63:0] d, input logic [63:0] m);
    req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d; bwe[k] = m;
  endtask

  initial begin
    logic [7:0] ord [2];
    logic [3:0] sa;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0; bwe[i] = '0;
      for (int k = 0; k < 2; k++) begin rv_cnt[i][k] = 0; last_rd[i][k] = '0; end
    end
    rsta = 1'b1;
    repeat (3) tick();
    rsta = 1'b0;

    // Single read of addr 3
    put(0, 1'b0, 4'd3, '0, '0);
    tick();
    idle();
    repeat (4) tick();
    chk("single_rd_d1", last_rd[0][0], 64'hA5);
    chk("single_rd_d2", last_rd[1][0], 64'hA5);
    chk("single_rd_p1_quiet", 64'(rv_cnt[0][1] + rv_cnt[1][1]), 64'd0);

    // Contention straight after reset
    rsta = 1'b1;
    tick();
    rsta = 1'b0;
    put(0, 1'b0, 4'd1, '0, '0);
    put(1, 1'b0, 4'd2, '0, '0);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      ord[0][2*j +: 2] = gnt_d[0];
      ord[1][2*j +: 2] = gnt_d[1];
      tick();
    end
    idle();
    repeat (4) tick();
    chk("contention_order_d1", ord[0], 8'b10_01_10_01);
    chk("contention_order_d2", ord[1], 8'b10_01_10_01);

    // Masked write then immediate read of the same word
    put(1, 1'b1, 4'd5, 64'hFFFF, 64'h00FF);
    tick();
    req[1] = 1'b0;
    put(0, 1'b0, 4'd5, '0, '0);
    tick();
    idle();
    repeat (5) tick();
    chk("wr_rd_merge_d1", last_rd[0][0], 64'h12FF);
    chk("wr_rd_merge_d2", last_rd[1][0], 64'h12FF);

    // Alternating reads on 8 consecutive cycles
    for (int j = 0; j < 8; j++) begin
      idle();
      sa = j[3:0] + 4'd6;
      put(j % 2, 1'b0, sa, '0, '0);
      tick();
    end
    idle();
    repeat (6) tick();
    chk("stream_last_d1", last_rd[0][1], 64'h1000_0000_0000_0DDD);
    chk("stream_last_d2", last_rd[1][1], 64'h1000_0000_0000_0DDD);

    // Reset while a read is in flight
    put(0, 1'b0, 4'd3, '0, '0);
    tick();
    idle();
    rsta = 1'b1;
    tick();
    rsta = 1'b0;
    put(0, 1'b0, 4'd9, '0, '0);
    put(1, 1'b0, 4'd10, '0, '0);
    @(negedge clk);
    chk("post_rst_ena_d1", ram_ena_d[0], 1'b0);
    chk("post_rst_ena_d2", ram_ena_d[1], 1'b0);
    chk("post_rst_gnt_d1", gnt_d[0], 2'b01);
    chk("post_rst_gnt_d2", gnt_d[1], 2'b01);
    tick();
    req[0] = 1'b0;
    tick();
    idle();
    repeat (6) tick();

    for (int i = 0; i < 2; i++) begin
      chk("rvalid_count_p0", 64'(rv_cnt[i][0]), 64'd9);
      chk("rvalid_count_p1", 64'(rv_cnt[i][1]), 64'd7);
      chk("sb_drained", 64'(sbq[i].size()), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
